// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU pipeline constants and types.
// Holds the PC width and the return-address-stack state enum.
package cpu_pkg;

    localparam int ADDR_W = 19;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } ras_state_e;

endpackage

// File: rtl/ret_addr_stack_if.sv
// ret_addr_stack_if: decode-side controls and fetch-side results
// of the return-address stack, as master/slave modports.
interface ret_addr_stack_if #(
    parameter int ADDR_W = 19,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              push;
    logic [ADDR_W-1:0] push_addr;
    logic              pop;
    logic              flush;
    logic [ADDR_W-1:0] pop_addr;
    logic              pop_valid;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              udf;

    modport master (
        output push, push_addr, pop, flush,
        input  pop_addr, pop_valid, count,
        input  full, empty, ovf, udf
    );

    modport slave (
        input  push, push_addr, pop, flush,
        output pop_addr, pop_valid, count,
        output full, empty, ovf, udf
    );

endinterface

// File: rtl/ras_regfile.sv
// ras_regfile: DEPTH x ADDR_W entry storage for the return stack.
// One clocked write port, one combinational read port.
module ras_regfile #(
    parameter int ADDR_W = 19,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [ADDR_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ADDR_W-1:0]        rdata
);
    logic [ADDR_W-1:0] mem [DEPTH];

    // Entry contents carry no reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// ret_addr_stack: return-address stack with pointer, count and flags.
// Define RAS_OVF_TRAP_EN for trap-on-overflow/underflow; else circular.
module ret_addr_stack #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DEPTH  = 16
) (
    input logic             clk,
    input logic             rst_n,
    ret_addr_stack_if.slave bus
);
    import cpu_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]     sp, sp_n, top, waddr;
    logic [CW-1:0]     cnt, cnt_n;
    logic [ADDR_W-1:0] pa, pa_n, rdata;
    logic              pv, pv_n, we, run;
    logic              is_full, is_empty;

`ifdef RAS_OVF_TRAP_EN
    ras_state_e st, st_n;
    logic       ovf_q, ovf_n, udf_q, udf_n;
`endif

    assign top      = sp - 1'b1;
    assign is_full  = (cnt == FULL_CNT);
    assign is_empty = (cnt == '0);

    ras_regfile #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_rf (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (bus.push_addr),
        .raddr (top),
        .rdata (rdata)
    );

    // Next-state: flush first, then stack ops in priority order.
    always_comb begin
        sp_n  = sp;
        cnt_n = cnt;
        pa_n  = pa;
        pv_n  = 1'b0;
        we    = 1'b0;
        waddr = sp;
`ifdef RAS_OVF_TRAP_EN
        st_n  = st;
        ovf_n = ovf_q;
        udf_n = udf_q;
        run   = (st == RUN);
`else
        run   = 1'b1;
`endif
        priority case (1'b1)
            bus.flush: begin
                sp_n  = '0;
                cnt_n = '0;
`ifdef RAS_OVF_TRAP_EN
                st_n  = RUN;
                ovf_n = 1'b0;
                udf_n = 1'b0;
`endif
            end
            !run: begin
            end
            bus.push && bus.pop && !is_empty: begin
                we    = 1'b1;
                waddr = top;
                pa_n  = rdata;
                pv_n  = 1'b1;
            end
            bus.push && is_full: begin
`ifdef RAS_OVF_TRAP_EN
                ovf_n = 1'b1;
                st_n  = TRAP;
`else
                we    = 1'b1;
                sp_n  = sp + 1'b1;
`endif
            end
            bus.push: begin
                we    = 1'b1;
                sp_n  = sp + 1'b1;
                cnt_n = cnt + 1'b1;
`ifdef RAS_OVF_TRAP_EN
                if (bus.pop) begin
                    udf_n = 1'b1;
                    st_n  = TRAP;
                end
`endif
            end
            bus.pop && !is_empty: begin
                pa_n  = rdata;
                pv_n  = 1'b1;
                sp_n  = top;
                cnt_n = cnt - 1'b1;
            end
            bus.pop: begin
`ifdef RAS_OVF_TRAP_EN
                udf_n = 1'b1;
                st_n  = TRAP;
`endif
            end
            default: begin
            end
        endcase
    end

    // Pointer, occupancy and registered pop result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp  <= '0;
            cnt <= '0;
            pa  <= '0;
            pv  <= 1'b0;
        end else begin
            sp  <= sp_n;
            cnt <= cnt_n;
            pa  <= pa_n;
            pv  <= pv_n;
        end
    end

`ifdef RAS_OVF_TRAP_EN
    // RUN/TRAP state and the sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= RUN;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            st    <= st_n;
            ovf_q <= ovf_n;
            udf_q <= udf_n;
        end
    end

    assign bus.ovf = ovf_q;
    assign bus.udf = udf_q;
`else
    assign bus.ovf = 1'b0;
    assign bus.udf = 1'b0;
`endif

    assign bus.pop_addr  = pa;
    assign bus.pop_valid = pv;
    assign bus.count     = cnt;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;

endmodule

// File: tb/tb_ret_addr_stack.sv
// tb_ret_addr_stack: table vectors, corner sequences and random
// traffic against a queue-based model of the return-address stack.
module tb_ret_addr_stack;

    localparam int AW = 19;
    localparam int D  = 16;
`ifdef RAS_OVF_TRAP_EN
    localparam bit TRAP_BUILD = 1'b1;
`else
    localparam bit TRAP_BUILD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    ret_addr_stack_if #(.ADDR_W(AW), .DEPTH(D)) bus ();

    ret_addr_stack #(.ADDR_W(AW), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    logic [AW-1:0] q [$];
    logic [AW-1:0] m_pa;
    logic          m_pv, m_ovf, m_udf, m_trap;

    typedef struct {
        logic          p;
        logic [AW-1:0] a;
        logic          o;
        logic          f;
        logic          epv;
        logic [AW-1:0] epa;
        int            ecnt;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pa   = '0;
        m_pv   = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_trap = 1'b0;
    endtask

    task automatic model_udf();
        if (TRAP_BUILD) begin
            m_udf  = 1'b1;
            m_trap = 1'b1;
        end
    endtask

    task automatic model(input logic p, input logic [AW-1:0] a,
                         input logic o, input logic f);
        m_pv = 1'b0;
        if (f) begin
            q.delete();
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_trap = 1'b0;
        end else if (!m_trap) begin
            if (p && o && q.size() > 0) begin
                m_pa = q[q.size()-1];
                q[q.size()-1] = a;
                m_pv = 1'b1;
            end else if (p) begin
                if (o) model_udf();
                if (q.size() == D) begin
                    if (TRAP_BUILD) begin
                        m_ovf  = 1'b1;
                        m_trap = 1'b1;
                    end else begin
                        void'(q.pop_front());
                        q.push_back(a);
                    end
                end else begin
                    q.push_back(a);
                end
            end else if (o) begin
                if (q.size() > 0) begin
                    m_pa = q.pop_back();
                    m_pv = 1'b1;
                end else begin
                    model_udf();
                end
            end
        end
    endtask

    task automatic check_all();
        check("pop_valid", 32'(bus.pop_valid), 32'(m_pv));
        check("pop_addr", 32'(bus.pop_addr), 32'(m_pa));
        check("count", 32'(bus.count), 32'(q.size()));
        check("full", 32'(bus.full), 32'(q.size() == D));
        check("empty", 32'(bus.empty), 32'(q.size() == 0));
        check("ovf", 32'(bus.ovf), 32'(m_ovf));
        check("udf", 32'(bus.udf), 32'(m_udf));
    endtask

    task automatic cycle(input logic p, input logic [AW-1:0] a,
                         input logic o, input logic f);
        bus.push      = p;
        bus.push_addr = a;
        bus.pop       = o;
        bus.flush     = f;
        @(posedge clk);
        #1;
        model(p, a, o, f);
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic step(input logic p, input logic [AW-1:0] a,
                        input logic o, input logic f);
        cycle(p, a, o, f);
        check_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          p, o, f;
        logic [AW-1:0] a;
        int            pct;

        tbl[0]  = '{1'b1, 19'h00010, 1'b0, 1'b0, 1'b0, 19'h00000, 1};
        tbl[1]  = '{1'b1, 19'h00020, 1'b0, 1'b0, 1'b0, 19'h00000, 2};
        tbl[2]  = '{1'b1, 19'h00030, 1'b0, 1'b0, 1'b0, 19'h00000, 3};
        tbl[3]  = '{1'b0, 19'h00000, 1'b1, 1'b0, 1'b1, 19'h00030, 2};
        tbl[4]  = '{1'b0, 19'h00000, 1'b1, 1'b0, 1'b1, 19'h00020, 1};
        tbl[5]  = '{1'b0, 19'h00000, 1'b1, 1'b0, 1'b1, 19'h00010, 0};
        tbl[6]  = '{1'b0, 19'h00000, 1'b0, 1'b0, 1'b0, 19'h00010, 0};
        tbl[7]  = '{1'b1, 19'h00100, 1'b0, 1'b0, 1'b0, 19'h00010, 1};
        tbl[8]  = '{1'b1, 19'h00200, 1'b1, 1'b0, 1'b1, 19'h00100, 1};
        tbl[9]  = '{1'b0, 19'h00000, 1'b1, 1'b0, 1'b1, 19'h00200, 0};
        tbl[10] = '{1'b0, 19'h00000, 1'b0, 1'b0, 1'b0, 19'h00200, 0};

        rst_n         = 1'b0;
        bus.push      = 1'b0;
        bus.push_addr = '0;
        bus.pop       = 1'b0;
        bus.flush     = 1'b0;
        model_reset();
        #2;
        check_all();
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].p, tbl[i].a, tbl[i].o, tbl[i].f);
            check($sformatf("tbl%0d_pv", i), 32'(bus.pop_valid),
                  32'(tbl[i].epv));
            check($sformatf("tbl%0d_pa", i), 32'(bus.pop_addr),
                  32'(tbl[i].epa));
            check($sformatf("tbl%0d_cnt", i), 32'(bus.count),
                  32'(tbl[i].ecnt));
            check($sformatf("tbl%0d_empty", i), 32'(bus.empty),
                  32'(tbl[i].ecnt == 0));
        end

        for (int i = 0; i < D; i++) begin
            step(1'b1, 19'(32'h1000 + i), 1'b0, 1'b0);
        end
        check("full_at_depth", 32'(bus.full), 32'd1);
        step(1'b1, 19'h7FFFF, 1'b0, 1'b0);
        check("count_after_17th", 32'(bus.count), 32'd16);
        step(1'b0, '0, 1'b1, 1'b0);
`ifdef RAS_OVF_TRAP_EN
        check("ovf_set", 32'(bus.ovf), 32'd1);
        check("trap_pop_ignored", 32'(bus.pop_valid), 32'd0);
`else
        check("wrap_pop_valid", 32'(bus.pop_valid), 32'd1);
        check("wrap_pop_addr", 32'(bus.pop_addr), 32'h7FFFF);
`endif
        step(1'b0, '0, 1'b0, 1'b1);
        check("flush_count", 32'(bus.count), 32'd0);

        step(1'b0, '0, 1'b1, 1'b0);
        check("empty_pop_pv", 32'(bus.pop_valid), 32'd0);
`ifdef RAS_OVF_TRAP_EN
        check("udf_set", 32'(bus.udf), 32'd1);
`endif
        step(1'b0, '0, 1'b0, 1'b1);
        check("udf_cleared", 32'(bus.udf), 32'd0);
        step(1'b1, 19'h00042, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("after_flush_pa", 32'(bus.pop_addr), 32'h00042);
        check("after_flush_pv", 32'(bus.pop_valid), 32'd1);

        for (int i = 0; i < 5; i++) begin
            step(1'b1, 19'(32'h2000 + i), 1'b0, 1'b0);
        end
        step(1'b1, 19'h00555, 1'b0, 1'b1);
        check("flush_push_cnt", 32'(bus.count), 32'd0);
        check("flush_push_empty", 32'(bus.empty), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("flush_push_dropped", 32'(bus.pop_valid), 32'd0);
        step(1'b0, '0, 1'b0, 1'b1);

        step(1'b1, 19'h00111, 1'b0, 1'b0);
        step(1'b1, 19'h00222, 1'b0, 1'b0);
        step(1'b1, 19'h00333, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_count", 32'(bus.count), 32'd0);
        check("arst_pv", 32'(bus.pop_valid), 32'd0);
        check("arst_pa", 32'(bus.pop_addr), 32'd0);
        check("arst_empty", 32'(bus.empty), 32'd1);
        check("arst_full", 32'(bus.full), 32'd0);
        check_all();
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            pct = ((i / 400) % 2 == 1) ? 75 : 35;
            p = ($urandom_range(0, 99) < pct);
            o = ($urandom_range(0, 99) < (100 - pct));
            f = ($urandom_range(0, 63) == 0) ||
                (m_trap && $urandom_range(0, 3) == 0);
            a = 19'($urandom);
            step(p, a, o, f);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
